// File: rtl/pc_stack_pkg.sv
// Shared constants for the program counter with call/return stack.
// Op encodings driven by the control FSM.
package pc_stack_pkg;

    localparam int unsigned OP_WIDTH = 3;

    localparam logic [OP_WIDTH-1:0] OP_HOLD   = 3'd0;
    localparam logic [OP_WIDTH-1:0] OP_INC    = 3'd1;
    localparam logic [OP_WIDTH-1:0] OP_LOAD   = 3'd2;
    localparam logic [OP_WIDTH-1:0] OP_BRREL  = 3'd3;
    localparam logic [OP_WIDTH-1:0] OP_CALL   = 3'd4;
    localparam logic [OP_WIDTH-1:0] OP_RET    = 3'd5;
    localparam logic [OP_WIDTH-1:0] OP_CLRERR = 3'd6;

endpackage

// File: rtl/pc_return_stack.sv
// LIFO of return addresses; push is ignored when full and pop when empty.
// rdata always shows the top entry (undefined when empty).
module pc_return_stack #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    count_m1;
    logic [PW-1:0]    wr_idx, rd_idx;
    logic             do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign count_m1 = count_q - CW'(1);
    assign wr_idx   = count_q[PW-1:0];
    assign rd_idx   = count_m1[PW-1:0];
    assign rdata    = mem_q[rd_idx];
    assign count    = count_q;

    always_comb begin
        count_d = count_q;
        if (do_push) begin
            count_d = count_q + CW'(1);
        end else if (do_pop) begin
            count_d = count_m1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage is not reset; writes are suppressed during reset so no stale push lands.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem_q[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with increment, load, PC-relative branch and call/return stack.
// Sticky overflow/underflow flags record illegal CALL/RET until cleared.
module pc_stack_unit
    import pc_stack_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 14,
    parameter int unsigned STACK_DEPTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [OP_WIDTH-1:0]          op,
    input  logic [ADDR_WIDTH-1:0]        address_in,
    input  logic [ADDR_WIDTH-1:0]        offset,
    output logic [ADDR_WIDTH-1:0]        address_out,
    output logic [$clog2(STACK_DEPTH):0] stack_count,
    output logic                         stack_empty,
    output logic                         stack_full,
    output logic                         stack_overflow,
    output logic                         stack_underflow
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] top_addr;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  push, pop;

    // Additions are truncated to ADDR_WIDTH, giving silent modular wrap.
    assign pc_inc = pc_q + ADDR_WIDTH'(1);

    pc_return_stack #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (pc_inc),
        .rdata (top_addr),
        .count (stack_count),
        .full  (stack_full),
        .empty (stack_empty)
    );

    always_comb begin
        pc_d  = pc_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        pop   = 1'b0;
        if (enable) begin
            unique case (op)
                OP_INC:   pc_d = pc_inc;
                OP_LOAD:  pc_d = address_in;
                OP_BRREL: pc_d = pc_q + offset;
                OP_CALL: begin
                    if (stack_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push = 1'b1;
                        pc_d = address_in;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        unf_d = 1'b1;
                    end else begin
                        pop  = 1'b1;
                        pc_d = top_addr;
                    end
                end
                OP_CLRERR: begin
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= RESET_ADDR;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign address_out     = pc_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: the driver queues the expected state after
// each clock, a monitor pops and compares it just after that clock edge.
module tb_pc_stack_unit;
    import pc_stack_pkg::*;

    localparam int unsigned AW = 14;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct {
        string         name;
        logic [AW-1:0] pc;
        int            count;
        logic          ovf;
        logic          unf;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                enable;
    logic [OP_WIDTH-1:0] op;
    logic [AW-1:0]       address_in;
    logic [AW-1:0]       offset;
    logic [AW-1:0]       address_out;
    logic [CW-1:0]       stack_count;
    logic                stack_empty, stack_full, stack_overflow, stack_underflow;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pc_stack_unit #(
        .ADDR_WIDTH  (AW),
        .STACK_DEPTH (DEPTH),
        .RESET_ADDR  ('0)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .op              (op),
        .address_in      (address_in),
        .offset          (offset),
        .address_out     (address_out),
        .stack_count     (stack_count),
        .stack_empty     (stack_empty),
        .stack_full      (stack_full),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    task automatic chk(input string name, input string field, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, req);
        end
    endtask

    // Monitor: every clock presents a new registered state; pop one expectation per edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "pc", int'(address_out), int'(e.pc));
            chk(e.name, "count", int'(stack_count), e.count);
            chk(e.name, "empty", int'(stack_empty), (e.count == 0) ? 1 : 0);
            chk(e.name, "full", int'(stack_full), (e.count == DEPTH) ? 1 : 0);
            chk(e.name, "ovf", int'(stack_overflow), int'(e.ovf));
            chk(e.name, "unf", int'(stack_underflow), int'(e.unf));
        end
    end

    task automatic step(input string name, input logic rn, input logic en,
                        input logic [OP_WIDTH-1:0] o, input logic [AW-1:0] a,
                        input logic [AW-1:0] off, input logic [AW-1:0] epc,
                        input int ecnt, input logic eovf, input logic eunf);
        exp_t e;
        @(negedge clk);
        rst_n      = rn;
        enable     = en;
        op         = o;
        address_in = a;
        offset     = off;
        e.name  = name;
        e.pc    = epc;
        e.count = ecnt;
        e.ovf   = eovf;
        e.unf   = eunf;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    initial begin
        logic [AW-1:0] ret_pc;
        rst_n = 1'b0; enable = 1'b0; op = OP_HOLD; address_in = '0; offset = '0;

        // Reset overrides an active INC; then enable low holds everything.
        step("rst0", 0, 1, OP_INC, 0, 0, 14'h0000, 0, 0, 0);
        step("rst1", 0, 1, OP_INC, 0, 0, 14'h0000, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("hold", 1, 0, OP_INC, 0, 0, 14'h0000, 0, 0, 0);

        // Load near the top and wrap via INC.
        step("load", 1, 1, OP_LOAD, 14'h3FFD, 0, 14'h3FFD, 0, 0, 0);
        step("inc1", 1, 1, OP_INC, 0, 0, 14'h3FFE, 0, 0, 0);
        step("inc2", 1, 1, OP_INC, 0, 0, 14'h3FFF, 0, 0, 0);
        step("inc3", 1, 1, OP_INC, 0, 0, 14'h0000, 0, 0, 0);
        step("inc4", 1, 1, OP_INC, 0, 0, 14'h0001, 0, 0, 0);

        // Relative branches, negative then positive.
        step("ld10", 1, 1, OP_LOAD, 14'h0010, 0, 14'h0010, 0, 0, 0);
        step("brneg", 1, 1, OP_BRREL, 0, 14'h3FFC, 14'h000C, 0, 0, 0);
        step("brpos", 1, 1, OP_BRREL, 0, 14'h0020, 14'h002C, 0, 0, 0);

        // Nested call/return.
        step("ld5", 1, 1, OP_LOAD, 14'h0005, 0, 14'h0005, 0, 0, 0);
        step("call1", 1, 1, OP_CALL, 14'h0100, 0, 14'h0100, 1, 0, 0);
        step("call2", 1, 1, OP_CALL, 14'h0200, 0, 14'h0200, 2, 0, 0);
        step("hold_call", 1, 0, OP_CALL, 14'h0300, 0, 14'h0200, 2, 0, 0);
        step("ret1", 1, 1, OP_RET, 0, 0, 14'h0101, 1, 0, 0);
        step("ret2", 1, 1, OP_RET, 0, 0, 14'h0006, 0, 0, 0);

        // Pushed return address wraps like any other increment.
        step("ld3fff", 1, 1, OP_LOAD, 14'h3FFF, 0, 14'h3FFF, 0, 0, 0);
        step("callw", 1, 1, OP_CALL, 14'h0100, 0, 14'h0100, 1, 0, 0);
        step("retw", 1, 1, OP_RET, 0, 0, 14'h0000, 0, 0, 0);
        step("ld6", 1, 1, OP_LOAD, 14'h0006, 0, 14'h0006, 0, 0, 0);

        // Fill: call i lands at 0x1000+16i; the first pushes 0x0007.
        for (int i = 0; i < 8; i++)
            step("fill", 1, 1, OP_CALL, AW'(14'h1000 + 16 * i), 0,
                 AW'(14'h1000 + 16 * i), i + 1, 0, 0);
        step("ovf", 1, 1, OP_CALL, 14'h2000, 0, 14'h1070, 8, 1, 0);
        step("ovf_hold", 1, 0, OP_CLRERR, 0, 0, 14'h1070, 8, 1, 0);
        for (int k = 0; k < 8; k++) begin
            int j;
            j = 7 - k;
            ret_pc = (j == 0) ? 14'h0007 : AW'(14'h1001 + 16 * (j - 1));
            step("drain", 1, 1, OP_RET, 0, 0, ret_pc, j, 1, 0);
        end
        step("unf", 1, 1, OP_RET, 0, 0, 14'h0007, 0, 1, 1);
        step("rsvd", 1, 1, 3'd7, 14'h0123, 14'h0001, 14'h0007, 0, 1, 1);
        step("clrerr", 1, 1, OP_CLRERR, 14'h0123, 0, 14'h0007, 0, 0, 0);

        // Reset arriving with a CALL must win and leave the stack empty.
        step("c30", 1, 1, OP_CALL, 14'h0030, 0, 14'h0030, 1, 0, 0);
        step("c40", 1, 1, OP_CALL, 14'h0040, 0, 14'h0040, 2, 0, 0);
        step("c50", 1, 1, OP_CALL, 14'h0050, 0, 14'h0050, 3, 0, 0);
        step("rst_call", 0, 1, OP_CALL, 14'h0060, 0, 14'h0000, 0, 0, 0);
        step("ret_after_rst", 1, 1, OP_RET, 0, 0, 14'h0000, 0, 0, 1);

        @(negedge clk);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
